// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle ARM control unit: FSM states, ALU
// operations, datapath mux selects, data-processing opcodes and condition codes.
package mc_pkg;

    // FSM state encodings
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9
    } state_t;

    localparam logic [3:0] ST_FETCH  = 4'd0;
    localparam logic [3:0] ST_DECODE = 4'd1;
    localparam logic [3:0] ST_MEMADR = 4'd2;
    localparam logic [3:0] ST_MEMRD  = 4'd3;
    localparam logic [3:0] ST_MEMWB  = 4'd4;
    localparam logic [3:0] ST_MEMWR  = 4'd5;
    localparam logic [3:0] ST_EXECR  = 4'd6;
    localparam logic [3:0] ST_EXECI  = 4'd7;
    localparam logic [3:0] ST_ALUWB  = 4'd8;
    localparam logic [3:0] ST_BRANCH = 4'd9;

    // ALU operations
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    // ALU B operand and result selects
    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    // Instruction classes (op field)
    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    // Data-processing cmd field
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    // Condition codes
    localparam logic [3:0] COND_EQ = 4'd0;
    localparam logic [3:0] COND_NE = 4'd1;
    localparam logic [3:0] COND_CS = 4'd2;
    localparam logic [3:0] COND_CC = 4'd3;
    localparam logic [3:0] COND_MI = 4'd4;
    localparam logic [3:0] COND_PL = 4'd5;
    localparam logic [3:0] COND_VS = 4'd6;
    localparam logic [3:0] COND_VC = 4'd7;
    localparam logic [3:0] COND_HI = 4'd8;
    localparam logic [3:0] COND_LS = 4'd9;
    localparam logic [3:0] COND_GE = 4'd10;
    localparam logic [3:0] COND_LT = 4'd11;
    localparam logic [3:0] COND_GT = 4'd12;
    localparam logic [3:0] COND_LE = 4'd13;
    localparam logic [3:0] COND_AL = 4'd14;

    // Map a data-processing cmd onto the four-function ALU; unknown cmds add
    function automatic logic [1:0] alu_op(input logic [3:0] cmd);
        logic [1:0] op;
        case (cmd)
            CMD_ADD: op = ALU_ADD;
            CMD_SUB: op = ALU_SUB;
            CMD_CMP: op = ALU_SUB;
            CMD_AND: op = ALU_AND;
            CMD_ORR: op = ALU_ORR;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/mc_condcheck.sv
// ARM condition evaluation against the NZCV flags; code 15 never executes.
module mc_condcheck
    import mc_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       condex
);

    logic n_s, z_s, c_s, v_s;
    assign {n_s, z_s, c_s, v_s} = flags;

    // Decode the condition field into an execute/annul decision
    always_comb begin
        condex = 1'b0;
        case (cond)
            COND_EQ: condex = z_s;
            COND_NE: condex = ~z_s;
            COND_CS: condex = c_s;
            COND_CC: condex = ~c_s;
            COND_MI: condex = n_s;
            COND_PL: condex = ~n_s;
            COND_VS: condex = v_s;
            COND_VC: condex = ~v_s;
            COND_HI: condex = c_s & ~z_s;
            COND_LS: condex = ~c_s | z_s;
            COND_GE: condex = (n_s == v_s);
            COND_LT: condex = (n_s != v_s);
            COND_GT: condex = ~z_s & (n_s == v_s);
            COND_LE: condex = z_s | (n_s != v_s);
            COND_AL: condex = 1'b1;
            default: condex = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle ARM control unit: FSM, NZCV flag register and datapath controls.
// Optional macro MC_MEMWAIT_EN: FETCH, MEMRD and MEMWR wait for mem_ready.
module mc_controller
    import mc_pkg::*;
#(
    parameter logic [3:0] FLAGS_RST = 4'b0000,
    parameter int         STATE_W   = 4
)
(
    input  logic               clk,
    input  logic               reset,
    input  logic [31:12]       Instr,
    input  logic [3:0]         ALUFlags,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic               AdrSrc,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               RegWrite,
    output logic [1:0]         ResultSrc,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ALUControl,
    output logic [1:0]         ImmSrc,
    output logic [1:0]         RegSrc,
    output logic [STATE_W-1:0] state_o
);

    logic [3:0] state_r, next_s, flags_r;
    logic       condex_s, mem_ok_s, unused_s;
    logic       pcwrite_s, memwrite_s, irwrite_s, regwrite_s;

    logic [3:0] cond_s, cmd_s, rd_s;
    logic [1:0] op_s;
    logic       imm_s, sbit_s, is_cmp_s, rd_pc_s;

    assign cond_s   = Instr[31:28];
    assign op_s     = Instr[27:26];
    assign imm_s    = Instr[25];
    assign cmd_s    = Instr[24:21];
    assign sbit_s   = Instr[20];
    assign rd_s     = Instr[15:12];
    assign is_cmp_s = (cmd_s == CMD_CMP);
    assign rd_pc_s  = (rd_s == 4'hF);

`ifdef MC_MEMWAIT_EN
    assign mem_ok_s = mem_ready;
    assign unused_s = ^Instr[19:16];
`else
    assign mem_ok_s = 1'b1;
    assign unused_s = ^{Instr[19:16], mem_ready};
`endif

    mc_condcheck u_condcheck (
        .cond   (cond_s),
        .flags  (flags_r),
        .condex (condex_s)
    );

    // State register; reset abandons any instruction in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_FETCH;
        end else begin
            state_r <= next_s;
        end
    end

    // NZCV capture at the end of an execute cycle for S-suffixed ops and CMP
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags_r <= FLAGS_RST;
        end else if (((state_r == ST_EXECR) || (state_r == ST_EXECI)) && (sbit_s || is_cmp_s)) begin
            flags_r <= ALUFlags;
        end
    end

    // Next-state selection
    always_comb begin
        next_s = ST_FETCH;
        case (state_r)
            ST_FETCH: begin
                if (mem_ok_s) next_s = ST_DECODE;
                else          next_s = ST_FETCH;
            end
            ST_DECODE: begin
                if (!condex_s) begin
                    next_s = ST_FETCH;
                end else begin
                    case (op_s)
                        OP_MEM: next_s = ST_MEMADR;
                        OP_DP: begin
                            if (imm_s) next_s = ST_EXECI;
                            else       next_s = ST_EXECR;
                        end
                        OP_BR:   next_s = ST_BRANCH;
                        default: next_s = ST_FETCH;
                    endcase
                end
            end
            ST_MEMADR: begin
                if (sbit_s) next_s = ST_MEMRD;
                else        next_s = ST_MEMWR;
            end
            ST_MEMRD: begin
                if (mem_ok_s) next_s = ST_MEMWB;
                else          next_s = ST_MEMRD;
            end
            ST_MEMWR: begin
                if (mem_ok_s) next_s = ST_FETCH;
                else          next_s = ST_MEMWR;
            end
            ST_MEMWB:  next_s = ST_FETCH;
            ST_EXECR:  next_s = ST_ALUWB;
            ST_EXECI:  next_s = ST_ALUWB;
            ST_ALUWB:  next_s = ST_FETCH;
            ST_BRANCH: next_s = ST_FETCH;
            default:   next_s = ST_FETCH;
        endcase
    end

    // Per-state datapath controls; a write to R15 is redirected into the PC
    always_comb begin
        pcwrite_s  = 1'b0;
        AdrSrc     = 1'b0;
        memwrite_s = 1'b0;
        irwrite_s  = 1'b0;
        regwrite_s = 1'b0;
        ResultSrc  = RES_ALUOUT;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SRCB_RD2;
        ALUControl = ALU_ADD;
        case (state_r)
            ST_FETCH: begin
                irwrite_s = mem_ok_s;
                pcwrite_s = mem_ok_s;
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALU;
            end
            ST_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALU;
            end
            ST_MEMADR: ALUSrcB = SRCB_IMM;
            ST_MEMRD:  AdrSrc  = 1'b1;
            ST_MEMWB: begin
                ResultSrc = RES_DATA;
                if (rd_pc_s) pcwrite_s  = 1'b1;
                else         regwrite_s = 1'b1;
            end
            ST_MEMWR: begin
                AdrSrc     = 1'b1;
                memwrite_s = 1'b1;
            end
            ST_EXECR: ALUControl = alu_op(cmd_s);
            ST_EXECI: begin
                ALUSrcB    = SRCB_IMM;
                ALUControl = alu_op(cmd_s);
            end
            ST_ALUWB: begin
                if (is_cmp_s)     regwrite_s = 1'b0;
                else if (rd_pc_s) pcwrite_s  = 1'b1;
                else              regwrite_s = 1'b1;
            end
            ST_BRANCH: begin
                ALUSrcB   = SRCB_IMM;
                ResultSrc = RES_ALU;
                pcwrite_s = 1'b1;
            end
            default: begin
                pcwrite_s = 1'b0;
            end
        endcase
    end

    // Write enables are held off while reset is low so nothing half-commits
    assign PCWrite  = pcwrite_s  & reset;
    assign MemWrite = memwrite_s & reset;
    assign IRWrite  = irwrite_s  & reset;
    assign RegWrite = regwrite_s & reset;

    assign ImmSrc  = op_s;
    assign RegSrc  = {(op_s == OP_MEM) & ~sbit_s, (op_s == OP_BR)};
    assign state_o = STATE_W'(state_r);

endmodule

// File: tb/tb_mc_controller.sv
// Table-driven bench for mc_controller: per-cycle vectors of instruction,
// ALU flags and expected state/controls, plus hand sequences for reset and
// memory-wait corner cases (wait checks active when MC_MEMWAIT_EN is defined).
module tb_mc_controller;

    logic        clk_s = 1'b0;
    logic        reset_s;
    logic [31:12] instr_s;
    logic [3:0]  aluflags_s;
    logic        mem_ready_s;
    logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA;
    logic [1:0]  ResultSrc, ALUSrcB, ALUControl, ImmSrc, RegSrc;
    logic [3:0]  state_o;

    mc_controller dut (
        .clk(clk_s), .reset(reset_s), .Instr(instr_s), .ALUFlags(aluflags_s),
        .mem_ready(mem_ready_s), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUControl(ALUControl), .ImmSrc(ImmSrc), .RegSrc(RegSrc), .state_o(state_o)
    );

    always #5 clk_s = ~clk_s;

    // ctl = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUControl}
    localparam logic [11:0] C_FETCH    = 12'b100101011000;
    localparam logic [11:0] C_DECODE   = 12'b000001011000;
    localparam logic [11:0] C_RESET    = 12'b000001011000;
    localparam logic [11:0] C_MEMADR   = 12'b000000000100;
    localparam logic [11:0] C_MEMRD    = 12'b010000000000;
    localparam logic [11:0] C_MEMWB    = 12'b000010100000;
    localparam logic [11:0] C_MEMWB_PC = 12'b100000100000;
    localparam logic [11:0] C_MEMWR    = 12'b011000000000;
    localparam logic [11:0] C_EXR_ADD  = 12'b000000000000;
    localparam logic [11:0] C_EXR_SUB  = 12'b000000000001;
    localparam logic [11:0] C_EXR_AND  = 12'b000000000010;
    localparam logic [11:0] C_EXI_ADD  = 12'b000000000100;
    localparam logic [11:0] C_EXI_ORR  = 12'b000000000111;
    localparam logic [11:0] C_ALUWB    = 12'b000010000000;
    localparam logic [11:0] C_ALUWB_PC = 12'b100000000000;
    localparam logic [11:0] C_NONE     = 12'b000000000000;
    localparam logic [11:0] C_BRANCH   = 12'b100001000100;

    typedef struct {
        logic [19:0] instr;
        logic [3:0]  flags;
        logic [3:0]  st;
        logic [11:0] ctl;
        logic [1:0]  imm;
        logic [1:0]  rs;
    } row_t;

    row_t        rows[$];
    logic [19:0] cur_instr;
    logic [1:0]  cur_imm, cur_rs;
    int          checks_n = 0;
    int          errors_n = 0;
    int          pulses_n;

    function automatic logic [19:0] mk(input logic [3:0] cond, input logic [1:0] op,
                                       input logic i, input logic [3:0] cmd,
                                       input logic s, input logic [3:0] rd);
        return {cond, op, i, cmd, s, 4'h0, rd};
    endfunction

    task automatic set_i(input logic [19:0] ins, input logic [1:0] imm, input logic [1:0] rs);
        cur_instr = ins; cur_imm = imm; cur_rs = rs;
    endtask

    task automatic r(input logic [3:0] fl, input logic [3:0] st, input logic [11:0] ctl);
        row_t x;
        x.instr = cur_instr; x.flags = fl; x.st = st; x.ctl = ctl;
        x.imm = cur_imm; x.rs = cur_rs;
        rows.push_back(x);
    endtask

    // FETCH then DECODE rows for the current instruction
    task automatic fd();
        r(4'h0, 4'd0, C_FETCH);
        r(4'h0, 4'd1, C_DECODE);
    endtask

    task automatic step();
        @(posedge clk_s);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks_n++;
        if (act !== exp) begin
            errors_n++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    initial begin
        logic [19:0] add_i, str_i, mi_i;
        logic [11:0] ctl_act;

        add_i = mk(4'hE, 2'b00, 1'b0, 4'b0100, 1'b0, 4'h1);
        str_i = mk(4'hE, 2'b01, 1'b0, 4'b1100, 1'b0, 4'h5);
        mi_i  = mk(4'h4, 2'b00, 1'b0, 4'b0100, 1'b0, 4'h1);

        // EQ straight after reset: flags are 0000, so annulled
        set_i(mk(4'h0, 2'b00, 1'b0, 4'b0100, 1'b0, 4'h1), 2'b00, 2'b00); fd();
        // ADD R1,R2,R3
        set_i(add_i, 2'b00, 2'b00); fd();
        r(4'h0, 4'd6, C_EXR_ADD); r(4'h0, 4'd8, C_ALUWB);
        // SUBS with ALUFlags Z set -> flags 0100
        set_i(mk(4'hE, 2'b00, 1'b0, 4'b0010, 1'b1, 4'h1), 2'b00, 2'b00); fd();
        r(4'b0100, 4'd6, C_EXR_SUB); r(4'h0, 4'd8, C_ALUWB);
        // ADDEQ immediate, no S: executes, flags unchanged
        set_i(mk(4'h0, 2'b00, 1'b1, 4'b0100, 1'b0, 4'h2), 2'b00, 2'b00); fd();
        r(4'h0, 4'd7, C_EXI_ADD); r(4'h0, 4'd8, C_ALUWB);
        // ADDNE annulled
        set_i(mk(4'h1, 2'b00, 1'b0, 4'b0100, 1'b0, 4'h3), 2'b00, 2'b00); fd();
        // Unlisted cmd (EOR) executes as ADD
        set_i(mk(4'hE, 2'b00, 1'b0, 4'b0001, 1'b0, 4'h4), 2'b00, 2'b00); fd();
        r(4'h0, 4'd6, C_EXR_ADD); r(4'h0, 4'd8, C_ALUWB);
        // AND register
        set_i(mk(4'hE, 2'b00, 1'b0, 4'b0000, 1'b0, 4'h4), 2'b00, 2'b00); fd();
        r(4'h0, 4'd6, C_EXR_AND); r(4'h0, 4'd8, C_ALUWB);
        // LDR R4: flags offered outside execute must not be taken
        set_i(mk(4'hE, 2'b01, 1'b0, 4'b1100, 1'b1, 4'h4), 2'b01, 2'b00); fd();
        r(4'hF, 4'd2, C_MEMADR); r(4'hF, 4'd3, C_MEMRD); r(4'hF, 4'd4, C_MEMWB);
        // STR
        set_i(str_i, 2'b01, 2'b10); fd();
        r(4'h0, 4'd2, C_MEMADR); r(4'h0, 4'd5, C_MEMWR);
        // LDR PC
        set_i(mk(4'hE, 2'b01, 1'b0, 4'b1100, 1'b1, 4'hF), 2'b01, 2'b00); fd();
        r(4'h0, 4'd2, C_MEMADR); r(4'h0, 4'd3, C_MEMRD); r(4'h0, 4'd4, C_MEMWB_PC);
        // CS annulled (C still 0)
        set_i(mk(4'h2, 2'b00, 1'b0, 4'b0100, 1'b0, 4'h1), 2'b00, 2'b00); fd();
        // B, cmd bits look like SUB but branch adds
        set_i(mk(4'hE, 2'b10, 1'b1, 4'b0010, 1'b0, 4'h0), 2'b10, 2'b01); fd();
        r(4'h0, 4'd9, C_BRANCH);
        // MOV PC via ORR immediate
        set_i(mk(4'hE, 2'b00, 1'b1, 4'b1100, 1'b0, 4'hF), 2'b00, 2'b00); fd();
        r(4'h0, 4'd7, C_EXI_ORR); r(4'h0, 4'd8, C_ALUWB_PC);
        // CMP without S bit: flags 1000 loaded, no register write
        set_i(mk(4'hE, 2'b00, 1'b0, 4'b1010, 1'b0, 4'h0), 2'b00, 2'b00); fd();
        r(4'b1000, 4'd6, C_EXR_SUB); r(4'h0, 4'd8, C_NONE);
        // MI executes (N=1)
        set_i(mi_i, 2'b00, 2'b00); fd();
        r(4'h0, 4'd6, C_EXR_ADD); r(4'h0, 4'd8, C_ALUWB);
        // EQ annulled (Z cleared by CMP)
        set_i(mk(4'h0, 2'b00, 1'b0, 4'b0100, 1'b0, 4'h1), 2'b00, 2'b00); fd();
        // LT executes (N!=V)
        set_i(mk(4'hB, 2'b00, 1'b0, 4'b0100, 1'b0, 4'h1), 2'b00, 2'b00); fd();
        r(4'h0, 4'd6, C_EXR_ADD); r(4'h0, 4'd8, C_ALUWB);
        // GT annulled
        set_i(mk(4'hC, 2'b00, 1'b0, 4'b0100, 1'b0, 4'h1), 2'b00, 2'b00); fd();
        // Condition 15 annulled
        set_i(mk(4'hF, 2'b00, 1'b0, 4'b0100, 1'b0, 4'h1), 2'b00, 2'b00); fd();
        // Undefined op 11 annulled
        set_i(mk(4'hE, 2'b11, 1'b0, 4'b0100, 1'b0, 4'h1), 2'b11, 2'b00); fd();
        // Closing ADD
        set_i(add_i, 2'b00, 2'b00); fd();
        r(4'h0, 4'd6, C_EXR_ADD); r(4'h0, 4'd8, C_ALUWB);

        // Reset phase
        reset_s = 1'b0; instr_s = add_i; aluflags_s = 4'h0; mem_ready_s = 1'b1;
        step(); step();
        chk("reset_state", 32'(state_o), 32'd0);
        chk("reset_ctl", 32'({PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                              ALUSrcA, ALUSrcB, ALUControl}), 32'(C_RESET));
        reset_s = 1'b1;

        // Table
        for (int i = 0; i < rows.size(); i++) begin
            instr_s = rows[i].instr;
            aluflags_s = rows[i].flags;
            #1;
            ctl_act = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                       ALUSrcA, ALUSrcB, ALUControl};
            checks_n++;
            if ({state_o, ctl_act, ImmSrc, RegSrc} !== {rows[i].st, rows[i].ctl, rows[i].imm, rows[i].rs}) begin
                errors_n++;
                $display("FAIL row %0d: got st=%0d ctl=%b imm=%b rs=%b, want st=%0d ctl=%b imm=%b rs=%b",
                         i, state_o, ctl_act, ImmSrc, RegSrc,
                         rows[i].st, rows[i].ctl, rows[i].imm, rows[i].rs);
            end
            step();
        end
        aluflags_s = 4'h0;

        // FETCH with mem_ready low
        instr_s = str_i;
        mem_ready_s = 1'b0;
`ifdef MC_MEMWAIT_EN
        pulses_n = 0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("wait_hold_state", 32'(state_o), 32'd0);
            if (IRWrite) pulses_n++;
            step();
        end
        mem_ready_s = 1'b1;
        #1;
        chk("wait_release_pulse", 32'({IRWrite, PCWrite}), 32'b11);
        if (IRWrite) pulses_n++;
        step();
        chk("wait_advance", 32'(state_o), 32'd1);
        chk("wait_irwrite_count", 32'(pulses_n), 32'd1);
`else
        #1;
        chk("nowait_pulse", 32'({IRWrite, PCWrite}), 32'b11);
        step();
        mem_ready_s = 1'b1;
        chk("nowait_advance", 32'(state_o), 32'd1);
`endif

        // STR into MEMWR, then reset mid-cycle
        step(); step();
        chk("memwr_reached", 32'({state_o, MemWrite, AdrSrc}), {26'd0, 4'd5, 2'b11});
        reset_s = 1'b0;
        #1;
        chk("memwr_reset_async", 32'({state_o, MemWrite}), {27'd0, 4'd0, 1'b0});
        step();
        reset_s = 1'b1;
        #1;
        chk("after_reset_fetch", 32'({state_o, IRWrite, PCWrite}), {26'd0, 4'd0, 2'b11});

        // ADD into ALUWB, then reset kills the register write
        instr_s = add_i;
        step(); step(); step();
        chk("aluwb_reached", 32'({state_o, RegWrite}), {27'd0, 4'd8, 1'b1});
        reset_s = 1'b0;
        #1;
        chk("aluwb_reset_async", 32'({state_o, RegWrite}), {27'd0, 4'd0, 1'b0});
        step();
        reset_s = 1'b1;

        // Flags were N=1 before reset; after reset MI must be annulled
        instr_s = mi_i;
        step(); step();
        chk("flags_reset_mi_annul", 32'(state_o), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks_n, errors_n);
        $finish;
    end

endmodule
